// File: rtl/queue_4x4b_rtl.sv
// queue_4x4b_rtl: 4-entry x 4-bit synchronous FIFO with a valid/ready handshake
// on both sides.
//
// Ports:
//   clk          single clock; all state updates happen on its rising edge
//   rst          asynchronous, active-high reset; clears pointers, count and storage
//   enq_val      producer presents a valid message
//   enq_rdy      queue can accept a message (not full); independent of deq_rdy
//   enq_msg      message to enqueue
//   deq_val      queue presents a valid message (not empty); no bypass from enq
//   deq_rdy      consumer accepts the head message
//   deq_msg      storage at the head pointer, driven every cycle
//   num_entries  current occupancy, 0..4
module queue_4x4b_rtl (
  input  logic       clk,
  input  logic       rst,
  input  logic       enq_val,
  output logic       enq_rdy,
  input  logic [3:0] enq_msg,
  output logic       deq_val,
  input  logic       deq_rdy,
  output logic [3:0] deq_msg,
  output logic [2:0] num_entries
);

  localparam int unsigned DEPTH = 4;

  logic [3:0] mem_q [DEPTH];
  logic [1:0] enq_ptr_q, enq_ptr_d;
  logic [1:0] deq_ptr_q, deq_ptr_d;
  logic [2:0] count_q, count_d;

  logic enq_fire;
  logic deq_fire;

  // Handshake status depends only on occupancy, so a full queue never accepts
  // a same-cycle enqueue and an empty queue never bypasses enq_msg.
  always_comb begin
    enq_rdy     = (count_q != 3'd4);
    deq_val     = (count_q != 3'd0);
    enq_fire    = enq_val && enq_rdy;
    deq_fire    = deq_val && deq_rdy;
    deq_msg     = mem_q[deq_ptr_q];
    num_entries = count_q;
  end

  always_comb begin
    enq_ptr_d = enq_ptr_q;
    deq_ptr_d = deq_ptr_q;
    count_d   = count_q;
    if (enq_fire) enq_ptr_d = enq_ptr_q + 2'd1;
    if (deq_fire) deq_ptr_d = deq_ptr_q + 2'd1;
    if (enq_fire && !deq_fire)      count_d = count_q + 3'd1;
    else if (deq_fire && !enq_fire) count_d = count_q - 3'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enq_ptr_q <= '0;
      deq_ptr_q <= '0;
      count_q   <= '0;
    end else begin
      enq_ptr_q <= enq_ptr_d;
      deq_ptr_q <= deq_ptr_d;
      count_q   <= count_d;
    end
  end

  // Flat 1-write/1-read storage: sequential write port, combinational read above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (enq_fire) begin
      mem_q[enq_ptr_q] <= enq_msg;
    end
  end

endmodule
